// File: rtl/pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid_reg
// Description : Pipeline stage register with a valid/ready handshake and a
//               two-entry skid buffer (head + skid). The handshake outputs
//               come from the state register only, so ready_o has no
//               combinational path from ready_i or valid_i. Flush empties the
//               stage and inserts a bubble: the control payload reads zero
//               whenever the stage holds no valid entry. The data payload is
//               never cleared except by reset.
//               All state updates happen on the falling edge of clk, in
//               step with the other stage registers.
// Ports       : clk          stage clock (falling-edge active)
//               rst_n        asynchronous active-low reset
//               flush_i      discard every held entry at this edge
//               valid_i      upstream entry present
//               ready_o      stage can accept an entry
//               data_i       upstream data payload   [DATA_WIDTH]
//               ctrl_i       upstream control payload [CTRL_WIDTH]
//               valid_o      downstream entry present
//               ready_i      downstream accepts the head entry
//               data_o       head data payload        [DATA_WIDTH]
//               ctrl_o       head control payload     [CTRL_WIDTH]
//               occupancy_o  number of held entries (0, 1 or 2)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [CTRL_WIDTH-1:0] ctrl_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
  output logic [1:0]            occupancy_o
);

  // State encoding equals the number of held entries, so occupancy_o is the
  // state register itself.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = '0;

  // --------------------------------------------------------------------------
  // State and storage
  // --------------------------------------------------------------------------
  logic [1:0]            state_q,     state_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic [CTRL_WIDTH-1:0] head_ctrl_q, head_ctrl_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;

  logic in_fire;
  logic out_fire;

  // --------------------------------------------------------------------------
  // Handshake outputs: decoded from state only. ready_o is also held low
  // while reset is asserted and rises as soon as rst_n deasserts.
  // --------------------------------------------------------------------------
  assign valid_o     = (state_q != ST_EMPTY);
  assign ready_o     = (state_q != ST_FULL) & rst_n;
  assign occupancy_o = state_q;

  assign data_o = head_data_q;
  // head_ctrl_q is zeroed on every entry into EMPTY, so this is already the
  // bubble value whenever valid_o is low.
  assign ctrl_o = head_ctrl_q;

  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush_i) begin
      // Flush wins over everything: a simultaneous accept is dropped, a
      // simultaneous delivery has already been seen downstream. Data and
      // skid contents are left alone; only the control bubble matters.
      state_d     = ST_EMPTY;
      head_ctrl_d = CTRL_BUBBLE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            head_data_d = data_i;
            head_ctrl_d = ctrl_i;
            state_d     = ST_HALF;
          end
        end

        ST_HALF: begin
          if (in_fire && out_fire) begin
            // Head leaves and the new entry takes its place directly.
            head_data_d = data_i;
            head_ctrl_d = ctrl_i;
          end else if (in_fire) begin
            // Downstream stalled: park the new entry behind the head.
            skid_data_d = data_i;
            skid_ctrl_d = ctrl_i;
            state_d     = ST_FULL;
          end else if (out_fire) begin
            head_ctrl_d = CTRL_BUBBLE;
            state_d     = ST_EMPTY;
          end
        end

        ST_FULL: begin
          // ready_o is low here, so no accept can coincide with this.
          if (out_fire) begin
            head_data_d = skid_data_q;
            head_ctrl_d = skid_ctrl_q;
            state_d     = ST_HALF;
          end
        end

        default: begin
          // Unreachable encoding: recover to an empty, bubbled stage.
          head_ctrl_d = CTRL_BUBBLE;
          state_d     = ST_EMPTY;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers: falling-edge clock, asynchronous active-low reset
  // --------------------------------------------------------------------------
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid_reg
// Description : Self-checking bench for pipe_stage_skid_reg. A queue holds
//               the entries the stage is expected to hold; entries are pushed
//               when an accept is predicted and popped when a delivery is
//               predicted, and the popped value is compared with the head
//               seen by the DUT at that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid_reg;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_i;
  logic [7:0]  ctrl_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic [7:0]  ctrl_o;
  logic [1:0]  occupancy_o;

  int checks   = 0;
  int failures = 0;

  // Expected contents of the stage, head first: {data, ctrl}.
  logic [39:0] sbq[$];

  time t_clk = 0;
  time t_rst = 0;

  pipe_stage_skid_reg #(
    .DATA_WIDTH(32),
    .CTRL_WIDTH(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .ctrl_i      (ctrl_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .ctrl_o      (ctrl_o),
    .occupancy_o (occupancy_o)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  always @(negedge clk) t_clk = $time;

  // ready_o may only move at an active clock edge or a reset change.
  always @(ready_o) begin
    if ($time != 0) begin
      checks++;
      if ($time != t_clk && $time != t_rst) begin
        failures++;
        $display("FAIL ready_o_timing: changed at %0t, last edge %0t, last reset %0t", $time, t_clk, t_rst);
      end
    end
  end

  // Called at a rising edge (mid-cycle). Applies inputs for the coming
  // falling edge, predicts accept/deliver from the model, samples the head
  // that will be delivered, updates the model and returns at the next rising
  // edge.
  task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] c,
                       input logic r, input logic f,
                       output logic fired, output logic [39:0] obs, output logic [39:0] expv);
    logic acc;
    valid_i = v; data_i = d; ctrl_i = c; ready_i = r; flush_i = f;
    acc   = v && (sbq.size() < 2);
    fired = (sbq.size() != 0) && r;
    obs   = {data_o, ctrl_o};
    expv  = '0;
    if (fired) expv = sbq.pop_front();
    if (f) sbq.delete();
    else if (acc) sbq.push_back({d, c});
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic test_reset();
    logic fired; logic [39:0] obs, expv;
    ready_i = 1'b0; flush_i = 1'b0;
    valid_i = 1'b1; data_i = 32'hDEADBEEF; ctrl_i = 8'hFF;
    rst_n = 1'b1;
    #1;
    t_rst = $time; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL reset_data: got %h want 0", data_o); end
    checks++; if (ctrl_o !== 8'h0) begin failures++; $display("FAIL reset_ctrl: got %h want 0", ctrl_o); end
    checks++; if (occupancy_o !== 2'd0) begin failures++; $display("FAIL reset_occ: got %0d want 0", occupancy_o); end
    t_rst = $time; rst_n = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b want 1", ready_o); end
    drive(1'b1, 32'hDEADBEEF, 8'hFF, 1'b0, 1'b0, fired, obs, expv);
    checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL first_valid: got %b want 1", valid_o); end
    checks++; if ({data_o, ctrl_o} !== {32'hDEADBEEF, 8'hFF}) begin failures++; $display("FAIL first_payload: got %h/%h want deadbeef/ff", data_o, ctrl_o); end
    checks++; if (occupancy_o !== 2'd1) begin failures++; $display("FAIL first_occ: got %0d want 1", occupancy_o); end
    drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, fired, obs, expv);
    checks++; if (!fired || obs !== 40'hDEADBEEF_FF) begin failures++; $display("FAIL first_deliver: got %h want deadbeefff", obs); end
    checks++; if (valid_o !== 1'b0 || ctrl_o !== 8'h0) begin failures++; $display("FAIL first_drain: got valid=%b ctrl=%h want 0/00", valid_o, ctrl_o); end
  endtask

  task automatic test_stream();
    logic fired; logic [39:0] obs, expv;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 8'(i + 16), 1'b1, 1'b0, fired, obs, expv);
      if (fired) begin
        checks++; if (obs !== expv) begin failures++; $display("FAIL stream_deliver: got %h want %h", obs, expv); end
      end
      checks++; if (data_o !== 32'(i) || ctrl_o !== 8'(i + 16)) begin failures++; $display("FAIL stream_head: got %h/%h want %h/%h", data_o, ctrl_o, i, i + 16); end
      checks++; if (occupancy_o !== 2'd1 || ready_o !== 1'b1) begin failures++; $display("FAIL stream_occ: got occ=%0d ready=%b want 1/1", occupancy_o, ready_o); end
    end
    drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, fired, obs, expv);
    checks++; if (!fired || obs !== {32'd8, 8'd24}) begin failures++; $display("FAIL stream_last: got %h want %h", obs, {32'd8, 8'd24}); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL stream_empty: got %b want 0", valid_o); end
  endtask

  task automatic test_skid();
    logic fired; logic [39:0] obs, expv;
    drive(1'b1, 32'hAAAA0001, 8'hA1, 1'b0, 1'b0, fired, obs, expv);
    drive(1'b1, 32'hBBBB0002, 8'hB2, 1'b0, 1'b0, fired, obs, expv);
    checks++; if (occupancy_o !== 2'd2 || ready_o !== 1'b0) begin failures++; $display("FAIL skid_full: got occ=%0d ready=%b want 2/0", occupancy_o, ready_o); end
    checks++; if (data_o !== 32'hAAAA0001) begin failures++; $display("FAIL skid_head: got %h want aaaa0001", data_o); end
    // Upstream keeps offering a new value while blocked; it must not enter.
    drive(1'b1, 32'hCCCC0003, 8'hC3, 1'b0, 1'b0, fired, obs, expv);
    checks++; if (occupancy_o !== 2'd2) begin failures++; $display("FAIL skid_blocked: got occ=%0d want 2", occupancy_o); end
    drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, fired, obs, expv);
    checks++; if (!fired || obs !== 40'hAAAA0001_A1) begin failures++; $display("FAIL skid_deliver_a: got %h want aaaa0001a1", obs); end
    checks++; if (occupancy_o !== 2'd1 || data_o !== 32'hBBBB0002) begin failures++; $display("FAIL skid_half: got occ=%0d data=%h want 1/bbbb0002", occupancy_o, data_o); end
    drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, fired, obs, expv);
    checks++; if (!fired || obs !== 40'hBBBB0002_B2) begin failures++; $display("FAIL skid_deliver_b: got %h want bbbb0002b2", obs); end
    checks++; if (valid_o !== 1'b0 || ctrl_o !== 8'h0 || occupancy_o !== 2'd0) begin failures++; $display("FAIL skid_empty: got valid=%b ctrl=%h occ=%0d want 0/00/0", valid_o, ctrl_o, occupancy_o); end
  endtask

  task automatic test_flush();
    logic fired; logic [39:0] obs, expv;
    drive(1'b1, 32'h11110001, 8'h31, 1'b0, 1'b0, fired, obs, expv);
    drive(1'b1, 32'h22220002, 8'h32, 1'b0, 1'b0, fired, obs, expv);
    drive(1'b1, 32'h33330003, 8'h33, 1'b0, 1'b1, fired, obs, expv);
    checks++; if (valid_o !== 1'b0 || ctrl_o !== 8'h0) begin failures++; $display("FAIL flush_bubble: got valid=%b ctrl=%h want 0/00", valid_o, ctrl_o); end
    checks++; if (occupancy_o !== 2'd0 || ready_o !== 1'b1) begin failures++; $display("FAIL flush_state: got occ=%0d ready=%b want 0/1", occupancy_o, ready_o); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, fired, obs, expv);
      checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL flush_no_ghost: got valid=%b data=%h want 0", valid_o, data_o); end
    end
    // Flush together with a delivery: the head still counts as delivered.
    drive(1'b1, 32'h44440004, 8'h34, 1'b0, 1'b0, fired, obs, expv);
    drive(1'b1, 32'h55550005, 8'h35, 1'b0, 1'b0, fired, obs, expv);
    drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b1, fired, obs, expv);
    checks++; if (!fired || obs !== 40'h44440004_34) begin failures++; $display("FAIL flush_out_deliver: got %h want 4444000434", obs); end
    checks++; if (valid_o !== 1'b0 || ctrl_o !== 8'h0 || occupancy_o !== 2'd0) begin failures++; $display("FAIL flush_out_empty: got valid=%b ctrl=%h occ=%0d want 0/00/0", valid_o, ctrl_o, occupancy_o); end
    // Data payload is not cleared by a flush.
    checks++; if (data_o !== 32'h44440004) begin failures++; $display("FAIL flush_data_hold: got %h want 44440004", data_o); end
  endtask

  task automatic test_random();
    logic fired; logic [39:0] obs, expv;
    logic v, r;
    for (int i = 0; i < 10000; i++) begin
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      drive(v, $urandom, 8'($urandom), r, 1'b0, fired, obs, expv);
      if (fired) begin
        checks++; if (obs !== expv) begin failures++; $display("FAIL random_order: cycle %0d got %h want %h", i, obs, expv); end
      end
      checks++; if (occupancy_o !== 2'(sbq.size()) || valid_o !== (sbq.size() != 0)) begin failures++; $display("FAIL random_occ: cycle %0d got occ=%0d valid=%b want %0d", i, occupancy_o, valid_o, sbq.size()); end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, fired, obs, expv);
      if (fired) begin
        checks++; if (obs !== expv) begin failures++; $display("FAIL random_drain: got %h want %h", obs, expv); end
      end
    end
    checks++; if (valid_o !== 1'b0 || ctrl_o !== 8'h0) begin failures++; $display("FAIL random_end_empty: got valid=%b ctrl=%h want 0/00", valid_o, ctrl_o); end
  endtask

  task automatic test_async_reset();
    logic fired; logic [39:0] obs, expv;
    drive(1'b1, 32'h77770007, 8'h47, 1'b0, 1'b0, fired, obs, expv);
    drive(1'b1, 32'h88880008, 8'h48, 1'b0, 1'b0, fired, obs, expv);
    checks++; if (occupancy_o !== 2'd2) begin failures++; $display("FAIL areset_prefill: got occ=%0d want 2", occupancy_o); end
    valid_i = 1'b0;
    #2;
    t_rst = $time; rst_n = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b0 || occupancy_o !== 2'd0) begin failures++; $display("FAIL areset_state: got valid=%b ready=%b occ=%0d want 0/0/0", valid_o, ready_o, occupancy_o); end
    checks++; if (data_o !== 32'h0 || ctrl_o !== 8'h0) begin failures++; $display("FAIL areset_payload: got %h/%h want 0/0", data_o, ctrl_o); end
    t_rst = $time; rst_n = 1'b1;
    sbq.delete();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, fired, obs, expv);
      checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL areset_no_stale: got valid=%b data=%h want 0", valid_o, data_o); end
    end
    drive(1'b1, 32'h99990009, 8'h49, 1'b1, 1'b0, fired, obs, expv);
    drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, fired, obs, expv);
    checks++; if (!fired || obs !== 40'h99990009_49) begin failures++; $display("FAIL areset_after: got %h want 9999000949", obs); end
  endtask

  initial begin
    rst_n = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    data_i = '0; ctrl_i = '0;
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid_reg.md
# pipe_stage_skid_reg

Parametrised pipeline stage register that supersedes the plain enable-gated stage registers between CPU stages. It carries a wide data payload and a separately handled control payload across one stage boundary. It replaces the single `en` stall with a full valid/ready handshake backed by a two-entry skid buffer, so that `ready_o` has no combinational path from `ready_i`. It adds flush with bubble insertion: control bits are forced to zero whenever the stage holds no valid instruction.

## Interface
Parameters:
- DATA_WIDTH, 32, width of the data payload (ALU result, store data, PC+4, …); never cleared by flush.
- CTRL_WIDTH, 8, width of the control payload (RegWrite, ResultSrc, JAL, AUIPC, rd address, …); zeroed whenever the stage is empty.

Ports:
- clk  in  1  stage clock; all state updates on the falling edge, matching the other stage registers.
- rst_n  in  1  reset, asynchronous, active-low.
- flush_i  in  1  discard all held entries this edge.
- valid_i  in  1  upstream entry present.
- ready_o  out  1  stage can accept an entry.
- data_i  in  DATA_WIDTH  upstream data payload.
- ctrl_i  in  CTRL_WIDTH  upstream control payload.
- valid_o  out  1  downstream entry present.
- ready_i  in  1  downstream accepts the entry.
- data_o  out  DATA_WIDTH  head data payload.
- ctrl_o  out  CTRL_WIDTH  head control payload; 0 when valid_o=0.
- occupancy_o  out  2  number of held entries (0, 1 or 2).

## Operation
- Storage: a head register (drives data_o/ctrl_o) and a skid register, each holding data and ctrl.
- States: EMPTY (occupancy 0), HALF (1, head valid), FULL (2, head and skid valid). Encoding is free; occupancy_o reflects the state.
- Outputs are decoded from state only:
  - valid_o = (state != EMPTY).
  - ready_o = (state != FULL) and rst_n high.
- Accept (IN) = valid_i & ready_o at the edge. Deliver (OUT) = valid_o & ready_i at the edge.
- Transitions (no flush):
  - EMPTY: IN → head ← input, HALF. Otherwise stay.
  - HALF: IN & OUT → head ← input, HALF. IN & !OUT → skid ← input, FULL. !IN & OUT → EMPTY. Neither → hold.
  - FULL: OUT → head ← skid, HALF. IN is impossible because ready_o=0. Otherwise hold everything.
- Ordering is strict FIFO; no entry is ever duplicated or dropped except by flush.
- Flush (highest priority):
  - state ← EMPTY and head ctrl ← 0; skid contents become don't-care.
  - A simultaneous IN is discarded.
  - A simultaneous OUT still counts as delivered downstream; the flush only empties this stage.
- Bubble rule: on every transition into EMPTY (OUT-drain, flush or reset), head ctrl ← 0, so ctrl_o=0 whenever valid_o=0.
- Data registers are never cleared except by reset and hold their last value while empty.

## Timing
- Reset (rst_n low, asynchronous):
  - valid_o=0, ready_o=0, data_o=0, ctrl_o=0, occupancy_o=0.
  - Skid register cleared.
  - ready_o rises combinationally when rst_n deasserts.
  - The first accept occurs on the first falling edge with rst_n high.
- Latency: input accepted at falling edge N appears on data_o/ctrl_o with valid_o=1 immediately after edge N, when the stage was EMPTY, or HALF with OUT at edge N.
- Throughput: one entry per cycle sustained while ready_i=1.
- One-cycle downstream stall: the stage absorbs one extra entry (FULL), then ready_o=0 until a delivery.
- ready_o changes only after a clock edge or reset; it never depends combinationally on ready_i or valid_i.
- Reset asserted mid-transfer: all entries are lost and outputs go to reset values immediately, without waiting for a clock edge.
- Upstream may drop valid_i or change payload while ready_o=0; only values present at an accepting edge are captured.

## Test plan
- Reset: hold rst_n=0 with valid_i=1, data_i=0xDEADBEEF, ctrl_i=0xFF → all outputs 0 and ready_o=0. Release → ready_o=1; next edge gives valid_o=1, data_o=0xDEADBEEF, ctrl_o=0xFF, occupancy_o=1.
- Streaming: ready_i=1, push data 1..8 on consecutive edges → data_o shows 1..8 on consecutive cycles; occupancy_o stays 1 and ready_o stays 1.
- Skid: while HALF holding A, ready_i=0, push B → occupancy_o=2, ready_o=0, data_o=A. Raise ready_i → A delivered, then B, then EMPTY with ctrl_o=0.
- Flush priority: FULL with A, B; assert flush_i with valid_i=1 carrying C → next cycle valid_o=0, ctrl_o=0, occupancy_o=0, ready_o=1; C is never delivered.
- Random backpressure: 10 000 cycles of random valid_i/ready_i, no flush → output sequence equals input sequence exactly; ready_o never observed to change without a clock edge.
- Async reset while FULL (mid-cycle pulse, no clock edge) → outputs zero immediately; no entry from before the reset ever appears after it.
